// File: rtl/alu_pkg.sv
// Package alu_pkg
//   Shared constants for the ALU requester side:
//   - ALU ctrl codes driven on alu_ctrl
//   - R-type funct codes accepted on the request port
//   - FSM state encoding of the sequencer
//   - sat_inc16: saturating 16-bit increment used by the optional stats counters
package alu_pkg;

  // ALU ctrl codes
  localparam logic [3:0] CTRL_ADD = 4'd0;
  localparam logic [3:0] CTRL_SUB = 4'd1;
  localparam logic [3:0] CTRL_XOR = 4'd2;
  localparam logic [3:0] CTRL_SLT = 4'd3;
  localparam logic [3:0] CTRL_SLL = 4'd5;
  localparam logic [3:0] CTRL_SRL = 4'd6;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Module alu_funct_decode
//   Combinational decode of an R-type funct field into the ALU ctrl code.
//   Ports:
//     funct_i     in  6  R-type funct field
//     ctrl_o      out 4  ALU ctrl code (CTRL_ADD for unknown functs)
//     legal_o     out 1  funct is one of the six supported codes
//     is_arith_o  out 1  op is add/sub, so ALU overflow/carry are meaningful
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       legal_o,
  output logic       is_arith_o
);

  always_comb begin
    ctrl_o     = CTRL_ADD;
    legal_o    = 1'b1;
    is_arith_o = 1'b0;
    case (funct_i)
      FUNCT_ADD: begin ctrl_o = CTRL_ADD; is_arith_o = 1'b1; end
      FUNCT_SUB: begin ctrl_o = CTRL_SUB; is_arith_o = 1'b1; end
      FUNCT_XOR: ctrl_o = CTRL_XOR;
      FUNCT_SLT: ctrl_o = CTRL_SLT;
      FUNCT_SLL: ctrl_o = CTRL_SLL;
      FUNCT_SRL: ctrl_o = CTRL_SRL;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Module alu_op_sequencer
//   Requester-side driver for a 32-bit ALU. Accepts one R-type op on a
//   valid/ready request port, holds operands and ctrl stable on the ALU inputs
//   for ALU_LAT cycles, samples result/flags, and returns them on a
//   valid/ready response port. Only one op is in flight at a time.
//   Parameters: WIDTH (datapath), ALU_LAT (1..15 cycles), TAG_W (tag width).
//   Ports:
//     clk, reset                      clock, asynchronous active-high reset
//     req_valid/req_ready             request handshake (ready only in IDLE)
//     req_funct/req_a/req_b/req_tag   request payload
//     alu_a/alu_b/alu_ctrl            registered drive to the ALU
//     alu_out/alu_ovf/alu_carry       ALU result inputs
//     rsp_valid/rsp_ready             response handshake
//     rsp_result/rsp_zero/rsp_ovf/rsp_carry/rsp_illegal/rsp_tag  response payload
//   Optional feature: define ALU_SEQ_STATS_EN to add stat_ops / stat_illegal,
//   16-bit saturating counts of handshaken responses and illegal responses.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_carry,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_illegal
`endif
);

  // WAIT lasts ALU_LAT cycles: the counter is loaded with ALU_LAT-1 and the
  // result is captured on the cycle it reads zero.
  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             is_arith_q;
  logic             req_ready_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_ctrl_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_ovf_q;
  logic             rsp_carry_q;
  logic             rsp_illegal_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic [3:0]       dec_ctrl;
  logic             dec_legal;
  logic             dec_arith;

  alu_funct_decode u_decode (
    .funct_i    (req_funct),
    .ctrl_o     (dec_ctrl),
    .legal_o    (dec_legal),
    .is_arith_o (dec_arith)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      is_arith_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= CTRL_ADD;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_carry_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_tag_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_tag_q   <= req_tag;
            if (dec_legal) begin
              alu_a_q       <= req_a;
              alu_b_q       <= req_b;
              alu_ctrl_q    <= dec_ctrl;
              is_arith_q    <= dec_arith;
              cnt_q         <= CNT_INIT;
              rsp_illegal_q <= 1'b0;
              state_q       <= ST_WAIT;
            end else begin
              // Illegal ops bypass the ALU entirely; its inputs keep the
              // previous op's values.
              rsp_result_q  <= '0;
              rsp_zero_q    <= 1'b1;
              rsp_ovf_q     <= 1'b0;
              rsp_carry_q   <= 1'b0;
              rsp_illegal_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
              state_q       <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_result_q <= alu_out;
            rsp_zero_q   <= (alu_out == '0);
            // Flags from logical/shift ops are meaningless, so mask them.
            rsp_ovf_q    <= is_arith_q & alu_ovf;
            rsp_carry_q  <= is_arith_q & alu_carry;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic        rsp_hs;
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_illegal_q, stat_illegal_d;

  assign rsp_hs         = rsp_valid_q & rsp_ready;
  assign stat_ops_d     = rsp_hs ? sat_inc16(stat_ops_q) : stat_ops_q;
  assign stat_illegal_d = (rsp_hs && rsp_illegal_q) ? sat_inc16(stat_illegal_q)
                                                    : stat_illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops_q     <= 16'd0;
      stat_illegal_q <= 16'd0;
    end else begin
      stat_ops_q     <= stat_ops_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_ops     = stat_ops_q;
  assign stat_illegal = stat_illegal_q;
`endif

  assign req_ready   = req_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_tag     = rsp_tag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer (ALU_LAT = 2). Provides a behavioural ALU
// that reacts to alu_a/alu_b/alu_ctrl; for non-arithmetic ops it drives
// ovf/carry high so that flag masking in the sequencer is observable.
// Stats checks are compiled in when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_ovf, alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_carry, rsp_illegal;
  logic [3:0]  rsp_tag;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_illegal;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .ALU_LAT(2), .TAG_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct   (req_funct),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out),
    .alu_ovf     (alu_ovf),
    .alu_carry   (alu_carry),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_ovf     (rsp_ovf),
    .rsp_carry   (rsp_carry),
    .rsp_illegal (rsp_illegal),
    .rsp_tag     (rsp_tag)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_illegal(stat_illegal)
`endif
  );

  // Behavioural ALU
  logic [32:0] sum33;
  always_comb begin
    alu_out   = 32'd0;
    alu_ovf   = 1'b1;
    alu_carry = 1'b1;
    sum33     = 33'd0;
    case (alu_ctrl)
      4'd0: begin
        sum33     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = sum33[31:0];
        alu_carry = sum33[32];
        alu_ovf   = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'd1: begin
        alu_out   = alu_a - alu_b;
        alu_carry = (alu_a >= alu_b);
        alu_ovf   = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      4'd2: alu_out = alu_a ^ alu_b;
      4'd3: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd5: alu_out = alu_a << alu_b[4:0];
      4'd6: alu_out = alu_a >> alu_b[4:0];
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge (caller ensures req_ready=1).
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
    req_valid = 1'b1;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
    step();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; an expired bound is reported as a failure.
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  // Complete a response handshake and return to IDLE.
  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check(tag, {30'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_funct = 6'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    req_tag   = 4'd0;
    rsp_ready = 1'b0;

    // Reset values
    #3;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_ctrl",  {28'd0, alu_ctrl}, 32'd0);
    check("rst_alu_a",     alu_a, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    step();
    reset = 1'b0;
    step();

    // add with signed overflow, latency = ALU_LAT+1
    issue(6'h20, 32'h7FFF_FFFF, 32'd1, 4'h3);
    check("add_req_ready_wait", {31'd0, req_ready}, 32'd0);
    check("add_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("add_alu_a", alu_a, 32'h7FFF_FFFF);
    check("add_valid_early0", {31'd0, rsp_valid}, 32'd0);
    step();
    check("add_valid_early1", {31'd0, rsp_valid}, 32'd0);
    step();
    check("add_valid_on_time", {31'd0, rsp_valid}, 32'd1);
    check("add_result", rsp_result, 32'h8000_0000);
    check("add_flags", {28'd0, rsp_zero, rsp_ovf, rsp_carry, rsp_illegal}, 32'b0100);
    check("add_tag", {28'd0, rsp_tag}, 32'h3);
    handshake("add_hs");

    // sub to zero, ctrl held at 1 during WAIT
    issue(6'h22, 32'h1234, 32'h1234, 4'h5);
    check("sub_ctrl_w0", {28'd0, alu_ctrl}, 32'd1);
    step();
    check("sub_ctrl_w1", {28'd0, alu_ctrl}, 32'd1);
    step();
    check("sub_valid", {31'd0, rsp_valid}, 32'd1);
    check("sub_result", rsp_result, 32'd0);
    check("sub_flags", {28'd0, rsp_zero, rsp_ovf, rsp_carry, rsp_illegal}, 32'b1010);
    check("sub_tag", {28'd0, rsp_tag}, 32'h5);
    handshake("sub_hs");

    // illegal funct: response next cycle, ALU inputs untouched
    issue(6'h3F, 32'hFFFF_0000, 32'h0000_FFFF, 4'hA);
    check("ill_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill_flag", {31'd0, rsp_illegal}, 32'd1);
    check("ill_result", rsp_result, 32'd0);
    check("ill_ovf_carry", {30'd0, rsp_ovf, rsp_carry}, 32'd0);
    check("ill_tag", {28'd0, rsp_tag}, 32'hA);
    check("ill_alu_ctrl_kept", {28'd0, alu_ctrl}, 32'd1);
    check("ill_alu_a_kept", alu_a, 32'h1234);
    handshake("ill_hs");

    // srl under backpressure; a competing request is ignored in RESP
    issue(6'h02, 32'h8000_0000, 32'd4, 4'h6);
    wait_rsp("srl_valid");
    req_valid = 1'b1;
    req_funct = 6'h20;
    req_a     = 32'h5555_5555;
    req_b     = 32'h1;
    req_tag   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_result", rsp_result, 32'h0800_0000);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("bp_flags_masked", {30'd0, rsp_ovf, rsp_carry}, 32'd0);
    check("bp_tag", {28'd0, rsp_tag}, 32'h6);
    check("bp_alu_a_kept", alu_a, 32'h8000_0000);
    req_valid = 1'b0;
    handshake("srl_hs");

    // xor, sll (shift from b[4:0]), slt signed
    issue(6'h26, 32'h0000_F0F0, 32'h0000_0FF0, 4'h1);
    wait_rsp("xor_valid");
    check("xor_result", rsp_result, 32'h0000_FF00);
    check("xor_flags_masked", {30'd0, rsp_ovf, rsp_carry}, 32'd0);
    handshake("xor_hs");

    issue(6'h00, 32'd1, 32'h25, 4'h2);
    wait_rsp("sll_valid");
    check("sll_result", rsp_result, 32'h20);
    check("sll_alu_ctrl", {28'd0, alu_ctrl}, 32'd5);
    handshake("sll_hs");

    issue(6'h2A, 32'hFFFF_FFFF, 32'd1, 4'h4);
    wait_rsp("slt_valid");
    check("slt_result", rsp_result, 32'd1);
    check("slt_zero", {31'd0, rsp_zero}, 32'd0);
    handshake("slt_hs");

    // reset during WAIT discards the op
    issue(6'h20, 32'd10, 32'd20, 4'h7);
    reset = 1'b1;
    #1;
    check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

`ifdef ALU_SEQ_STATS_EN
    check("stat_ops_clear", {16'd0, stat_ops}, 32'd0);
    issue(6'h20, 32'd1, 32'd2, 4'h0); wait_rsp("st_v0"); handshake("st_h0");
    issue(6'h3E, 32'd1, 32'd2, 4'h1); wait_rsp("st_v1"); handshake("st_h1");
    issue(6'h26, 32'd1, 32'd2, 4'h2); wait_rsp("st_v2"); handshake("st_h2");
    issue(6'h01, 32'd1, 32'd2, 4'h3); wait_rsp("st_v3"); handshake("st_h3");
    issue(6'h02, 32'd8, 32'd1, 4'h4); wait_rsp("st_v4"); handshake("st_h4");
    check("stat_ops", {16'd0, stat_ops}, 32'd5);
    check("stat_illegal", {16'd0, stat_illegal}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
